// File: rtl/mod7_pkg.sv
// Shared types and helpers for the mod-7 JK flip-flop driver.
// Holds the FSM state type, the count ceiling and the JK excitation and step functions.
package mod7_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2
   } state_e;

   localparam logic [2:0] MOD7_MAX = 3'd6;

   // Returns {j, k} that moves one JK stage from q_bit to t_bit without toggling.
   function automatic logic [1:0] jk_excite(input logic q_bit, input logic t_bit);
      logic [1:0] jk;
      case ({q_bit, t_bit})
         2'b01:   jk = 2'b10;
         2'b10:   jk = 2'b01;
         default: jk = 2'b00;
      endcase
      return jk;
   endfunction

   function automatic logic [2:0] mod7_next(input logic [2:0] c, input logic up);
      logic [2:0] n;
      if (up) begin
         n = (c >= MOD7_MAX) ? 3'd0 : c + 3'd1;
      end else begin
         n = (c == 3'd0) ? MOD7_MAX : c - 3'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-DIV prescaler: tick is high on the enabled cycle that completes DIV increments.
// The count restarts on clr or on its own tick.
module tick_prescaler #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = inc && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr || tick) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mod7_jk_driver.sv
// Drives three external JK flip-flops through a mod-7 count sequence from a shadow count,
// then checks the stage feedback against that shadow and latches a sticky error on mismatch.
module mod7_jk_driver
   import mod7_pkg::*;
#(
   parameter int unsigned DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [2:0] load_val,
   input  logic [2:0] q,
   output logic [2:0] j,
   output logic [2:0] k,
   output logic       tc,
   output logic       err,
   output logic [2:0] cnt
);

   state_e     state_q;
   logic [2:0] cnt_q;
   logic [2:0] target_q;
   logic [2:0] j_q;
   logic [2:0] k_q;
   logic       tc_q;
   logic       err_q;

   logic       idle;
   logic       tick;
   logic       presc_inc;
   logic       presc_clr;
   logic       wrap;
   logic [2:0] load_tgt;
   logic [2:0] target_d;
   logic [2:0] exc_j;
   logic [2:0] exc_k;

   assign idle      = (state_q == IDLE);
   assign presc_inc = idle && en;
   assign presc_clr = idle && (load || tick);

   tick_prescaler #(
      .DIV (DIV)
   ) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (presc_inc),
      .clr   (presc_clr),
      .tick  (tick)
   );

   assign load_tgt = (load_val == 3'd7) ? 3'd0 : load_val;
   assign target_d = load ? load_tgt : mod7_next(cnt_q, up);
   assign wrap     = up ? (cnt_q == MOD7_MAX) : (cnt_q == 3'd0);

   always_comb begin
      exc_j = '0;
      exc_k = '0;
      for (int i = 0; i < 3; i++) begin
         {exc_j[i], exc_k[i]} = jk_excite(q[i], target_d[i]);
      end
   end

   // Reset holds k high so the downstream stages are cleared while rst_n is low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         target_q <= 3'd0;
         j_q      <= 3'b000;
         k_q      <= 3'b111;
         tc_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               j_q <= 3'b000;
               k_q <= 3'b000;
               if (load || tick) begin
                  state_q  <= DRIVE;
                  target_q <= target_d;
                  j_q      <= exc_j;
                  k_q      <= exc_k;
                  tc_q     <= !load && wrap;
               end
            end
            DRIVE: begin
               cnt_q   <= target_q;
               j_q     <= 3'b000;
               k_q     <= 3'b000;
               tc_q    <= 1'b0;
               state_q <= CHECK;
            end
            CHECK: begin
               if (q != cnt_q) begin
                  err_q <= 1'b1;
               end
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign j   = j_q;
   assign k   = k_q;
   assign tc  = tc_q;
   assign err = err_q;
   assign cnt = cnt_q;

endmodule

// File: tb/tb_mod7_jk_driver.sv
// Directed bench for mod7_jk_driver with behavioural JK stages closing the feedback loop.
// A second instance with DIV=3 exercises enable gating of the prescaler.
module tb_mod7_jk_driver;
   import mod7_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       load;
   logic [2:0] load_val;
   logic       fault;
   logic [2:0] j, k, cnt;
   logic       tc, err;
   logic [2:0] q_stage = 3'b101;
   logic [2:0] q_fb;

   logic       en3;
   logic [2:0] j3, k3, cnt3;
   logic       tc3, err3;
   logic [2:0] q3_stage = 3'b011;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [2:0] jk_stages(input logic [2:0] qv, input logic [2:0] jv,
                                            input logic [2:0] kv);
      logic [2:0] n;
      for (int i = 0; i < 3; i++) begin
         case ({jv[i], kv[i]})
            2'b10:   n[i] = 1'b1;
            2'b01:   n[i] = 1'b0;
            2'b11:   n[i] = ~qv[i];
            default: n[i] = qv[i];
         endcase
      end
      return n;
   endfunction

   always @(posedge clk) q_stage  <= jk_stages(q_stage, j, k);
   always @(posedge clk) q3_stage <= jk_stages(q3_stage, j3, k3);

   assign q_fb = fault ? (q_stage & 3'b101) : q_stage;

   mod7_jk_driver #(.DIV(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .q        (q_fb),
      .j        (j),
      .k        (k),
      .tc       (tc),
      .err      (err),
      .cnt      (cnt)
   );

   mod7_jk_driver #(.DIV(3)) dut3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en3),
      .up       (up),
      .load     (1'b0),
      .load_val (3'd0),
      .q        (q3_stage),
      .j        (j3),
      .k        (k3),
      .tc       (tc3),
      .err      (err3),
      .cnt      (cnt3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // n_idle edges lead into DRIVE, then one edge each through DRIVE and CHECK.
   task automatic run_step(input int n_idle, input logic [2:0] ej, input logic [2:0] ek,
                           input logic etc, input logic [2:0] ecnt, input logic eerr,
                           input string tag);
      if (n_idle > 1) begin
         repeat (n_idle - 1) edge1();
         chk({tag, " pre_jk"}, {26'd0, j, k}, 32'd0);
      end
      edge1();
      chk({tag, " drive_j"}, {29'd0, j}, {29'd0, ej});
      chk({tag, " drive_k"}, {29'd0, k}, {29'd0, ek});
      chk({tag, " drive_tc"}, {31'd0, tc}, {31'd0, etc});
      load = 1'b0;
      edge1();
      chk({tag, " cnt"}, {29'd0, cnt}, {29'd0, ecnt});
      chk({tag, " check_jk"}, {26'd0, j, k}, 32'd0);
      chk({tag, " check_tc"}, {31'd0, tc}, 32'd0);
      edge1();
      chk({tag, " err"}, {31'd0, err}, {31'd0, eerr});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] uj [7];
      logic [2:0] uk [7];
      uj = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010, 3'b000};
      uk = '{3'b000, 3'b001, 3'b000, 3'b011, 3'b000, 3'b001, 3'b110};

      rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 3'd0;
      fault = 1'b0; en3 = 1'b0;

      // Reset values after two low cycles.
      edge1();
      edge1();
      chk("rst j", {29'd0, j}, 32'd0);
      chk("rst k", {29'd0, k}, 32'd7);
      chk("rst cnt", {29'd0, cnt}, 32'd0);
      chk("rst tc", {31'd0, tc}, 32'd0);
      chk("rst err", {31'd0, err}, 32'd0);
      chk("rst state", 32'(dut.state_q), 32'(IDLE));
      chk("rst stages", {29'd0, q_stage}, 32'd0);
      chk("rst k3", {29'd0, k3}, 32'd7);

      rst_n = 1'b1;
      edge1();
      chk("post_rst j", {29'd0, j}, 32'd0);
      chk("post_rst k", {29'd0, k}, 32'd0);

      // Full up cycle, wrapping 6 -> 0 on the last step.
      en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         run_step(4, uj[i], uk[i], (i == 6), 3'((i + 1) % 7), 1'b0, $sformatf("up%0d", i));
      end
      chk("up stages", {29'd0, q_stage}, 32'd0);

      // Down count from 0 wraps to 6, then 5.
      up = 1'b0;
      run_step(4, 3'b110, 3'b000, 1'b1, 3'd6, 1'b0, "dn0");
      run_step(4, 3'b001, 3'b010, 1'b0, 3'd5, 1'b0, "dn1");

      // Loads: 2, then 5 from 2, then 7 which lands on 0.
      load_val = 3'd2; load = 1'b1;
      run_step(1, 3'b010, 3'b101, 1'b0, 3'd2, 1'b0, "ld2");
      load_val = 3'd5; load = 1'b1;
      run_step(1, 3'b101, 3'b010, 1'b0, 3'd5, 1'b0, "ld5");
      load_val = 3'd7; load = 1'b1;
      run_step(1, 3'b000, 3'b101, 1'b0, 3'd0, 1'b0, "ld7");

      // Load coincides with a wrapping prescaler step: load wins, no tc.
      repeat (3) edge1();
      load_val = 3'd3; load = 1'b1;
      run_step(1, 3'b011, 3'b000, 1'b0, 3'd3, 1'b0, "ldpri");

      // Step down to 2 while q[1] is forced low in the feedback.
      repeat (3) edge1();
      edge1();
      chk("flt drive_j", {29'd0, j}, 32'd0);
      chk("flt drive_k", {29'd0, k}, 32'd1);
      fault = 1'b1;
      edge1();
      chk("flt cnt", {29'd0, cnt}, 32'd2);
      chk("flt err_in_check", {31'd0, err}, 32'd0);
      edge1();
      chk("flt err_set", {31'd0, err}, 32'd1);
      fault = 1'b0;
      up = 1'b1;
      run_step(4, 3'b001, 3'b000, 1'b0, 3'd3, 1'b1, "sticky");

      // Reset asserted for two cycles in the middle of a DRIVE.
      repeat (3) edge1();
      edge1();
      chk("mid drive_j", {29'd0, j}, 32'd4);
      chk("mid drive_k", {29'd0, k}, 32'd3);
      rst_n = 1'b0;
      edge1();
      chk("mid rst1 jk", {26'd0, j, k}, 32'd7);
      edge1();
      chk("mid rst2 jk", {26'd0, j, k}, 32'd7);
      chk("mid rst err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;
      en = 1'b0;
      edge1();
      chk("mid post jk", {26'd0, j, k}, 32'd0);
      chk("mid post cnt", {29'd0, cnt}, 32'd0);
      chk("mid post err", {31'd0, err}, 32'd0);
      chk("mid post state", 32'(dut.state_q), 32'(IDLE));
      chk("mid post stages", {29'd0, q_stage}, 32'd0);

      // Enable gating on the DIV=3 instance: 1, 0, 0, 1, 1.
      en3 = 1'b1;
      edge1();
      en3 = 1'b0;
      edge1();
      edge1();
      chk("gate hold", {30'd0, dut3.u_presc.cnt_q}, 32'd1);
      chk("gate idle_j", {29'd0, j3}, 32'd0);
      en3 = 1'b1;
      edge1();
      chk("gate not_yet", {29'd0, j3}, 32'd0);
      edge1();
      chk("gate drive_j", {29'd0, j3}, 32'd1);
      chk("gate drive_k", {29'd0, k3}, 32'd0);
      chk("gate drive_tc", {31'd0, tc3}, 32'd0);
      en3 = 1'b0;
      edge1();
      chk("gate cnt", {29'd0, cnt3}, 32'd1);
      edge1();
      chk("gate err", {31'd0, err3}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
